// File: rtl/reg_file_sb.sv
// Register file with 2 async read ports, 1 sync write port, x0 hardwired to zero,
// a post-reset clear sweep and a per-register pending-write scoreboard.
// Optional macro WRITE_BYPASS_EN forwards a same-cycle write to the read ports and busy flags.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_addr,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  init_busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] A0_IDX   = ADDR_WIDTH'(10);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pend;
  logic [NUM_REGS-1:0]   w_pend_next;
  logic                  w_run;
  logic                  w_wr_hit;
  logic                  w_set_hit;

  assign w_run     = (r_state == S_RUN);
  assign w_wr_hit  = w_run && WE3 && (AD3 != '0);
  assign w_set_hit = w_run && pend_set && (pend_addr != '0);
  assign init_busy = (r_state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == LAST_IDX) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_CLEAR;
    endcase
  end

  // Counter parks at the last index once the sweep is done, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                                           r_cnt <= '0;
    else if (r_state == S_CLEAR && r_cnt != LAST_IDX)  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)   r_regs[r_cnt] <= '0;
    else if (!rst && w_wr_hit) r_regs[AD3]  <= WD3;
  end

  // Set is applied after clear: a new producer issued in the same cycle wins.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr_hit)  w_pend_next[AD3]       = 1'b0;
    if (w_set_hit) w_pend_next[pend_addr] = 1'b1;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_next;
  end

  always_comb begin
    RD1   = '0;
    RD2   = '0;
    a0    = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (w_run) begin
      if (AD1 != '0) RD1 = r_regs[AD1];
      if (AD2 != '0) RD2 = r_regs[AD2];
      a0    = r_regs[A0_IDX];
      busy1 = r_pend[AD1];
      busy2 = r_pend[AD2];
`ifdef WRITE_BYPASS_EN
      if (w_wr_hit && AD3 == AD1) begin
        RD1   = WD3;
        busy1 = 1'b0;
      end
      if (w_wr_hit && AD3 == AD2) begin
        RD2   = WD3;
        busy2 = 1'b0;
      end
      if (w_wr_hit && AD3 == A0_IDX) a0 = WD3;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: sweep/reset sequences, a directed vector table and a
// randomized run checked against a behavioural model of the register file.
module tb_reg_file_sb;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3, pend_addr;
  logic        WE3, pend_set;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, a0;
  logic        busy1, busy2, init_busy;

  int total = 0;
  int bad   = 0;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .pend_set(pend_set), .pend_addr(pend_addr), .RD1(RD1), .RD2(RD2), .a0(a0),
    .busy1(busy1), .busy2(busy2), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required finish before it");
    $fatal(1);
  end

  // Behavioural model: register contents, pending flags and remaining sweep cycles.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          m_clear_left = 32;

  function automatic logic [31:0] m_rd(input logic [4:0] ad);
    if (m_clear_left > 0 || ad == 5'd0) return 32'h0;
    if (BYP && WE3 && AD3 != 5'd0 && AD3 == ad) return WD3;
    return m_regs[ad];
  endfunction

  function automatic logic m_busy(input logic [4:0] ad);
    if (m_clear_left > 0) return 1'b0;
    if (BYP && WE3 && AD3 != 5'd0 && AD3 == ad) return 1'b0;
    return m_pend[ad];
  endfunction

  task automatic m_step();
    if (rst) begin
      m_clear_left = 32;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0)
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      if (WE3 && AD3 != 5'd0) begin
        m_regs[AD3] = WD3;
        m_pend[AD3] = 1'b0;
      end
      if (pend_set && pend_addr != 5'd0) m_pend[pend_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    AD1 = 5'd0; AD2 = 5'd0; AD3 = 5'd0; WE3 = 1'b0; WD3 = 32'h0;
    pend_set = 1'b0; pend_addr = 5'd0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) advance();
    rst = 1'b0;
    #1;
    chk("init_busy_after_rst", {31'b0, init_busy}, 32'h1);
  endtask

  // Counts cycles with init_busy high; optionally attempts a write/pend_set mid-sweep.
  task automatic sweep_count(input bit poke, output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      idle_inputs();
      if (poke && n == 5) begin
        WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'hFFFF_FFFF;
        pend_set = 1'b1; pend_addr = 5'd3; AD1 = 5'd3;
        #1;
        chk("rd1_during_clear", RD1, 32'h0);
        chk("busy1_during_clear", {31'b0, busy1}, 32'h0);
      end
      n++;
      advance();
    end
    idle_inputs();
  endtask

  typedef struct {
    logic [4:0]  ad1, ad2, ad3;
    logic        we;
    logic [31:0] wd;
    logic        ps;
    logic [4:0]  pa;
    logic [31:0] e_rd1, e_rd2, e_a0;
    logic        e_b1, e_b2;
  } vec_t;

  vec_t tbl [14];
  int   n;

  initial begin
    logic [31:0] row0_a0;
    row0_a0 = BYP ? 32'h2A : 32'h0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    //          ad1    ad2    ad3    we    wd            ps    pa     rd1           rd2           a0       b1    b2
    tbl[0]  = '{5'd0,  5'd3,  5'd10, 1'b1, 32'h2A,       1'b0, 5'd0,  32'h0,        32'h0,        row0_a0, 1'b0, 1'b0};
    tbl[1]  = '{5'd10, 5'd0,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h2A,       32'h0,        32'h2A,  1'b0, 1'b0};
    tbl[2]  = '{5'd0,  5'd10, 5'd0,  1'b1, 32'hDEADBEEF, 1'b1, 5'd0,  32'h0,        32'h2A,       32'h2A,  1'b0, 1'b0};
    tbl[3]  = '{5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h2A,  1'b0, 1'b0};
    tbl[4]  = '{5'd5,  5'd10, 5'd0,  1'b0, 32'h0,        1'b1, 5'd5,  32'h0,        32'h2A,       32'h2A,  1'b0, 1'b0};
    tbl[5]  = '{5'd5,  5'd0,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h2A,  1'b1, 1'b0};
    tbl[6]  = '{5'd7,  5'd10, 5'd5,  1'b1, 32'h55,       1'b0, 5'd0,  32'h0,        32'h2A,       32'h2A,  1'b0, 1'b0};
    tbl[7]  = '{5'd5,  5'd5,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h55,       32'h55,       32'h2A,  1'b0, 1'b0};
    tbl[8]  = '{5'd9,  5'd10, 5'd5,  1'b1, 32'h66,       1'b1, 5'd5,  32'h0,        32'h2A,       32'h2A,  1'b0, 1'b0};
    tbl[9]  = '{5'd5,  5'd5,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h66,       32'h66,       32'h2A,  1'b1, 1'b1};
    tbl[10] = '{5'd7,  5'd10, 5'd9,  1'b1, 32'h1234,     1'b1, 5'd7,  32'h0,        32'h2A,       32'h2A,  1'b0, 1'b0};
    tbl[11] = '{5'd7,  5'd9,  5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        32'h1234,     32'h2A,  1'b1, 1'b0};
    tbl[12] = '{5'd7,  5'd5,  5'd0,  1'b0, 32'h0,        1'b1, 5'd7,  32'h0,        32'h66,       32'h2A,  1'b1, 1'b1};
    tbl[13] = '{5'd7,  5'd10, 5'd0,  1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        32'h2A,       32'h2A,  1'b1, 1'b0};

    idle_inputs();
    rst = 1'b1;

    // Reset held two cycles, sweep length, writes lost mid-sweep, all registers zero.
    do_reset(2);
    chk("rd1_at_reset", RD1, 32'h0);
    chk("a0_at_reset", a0, 32'h0);
    sweep_count(1'b1, n);
    chk("sweep_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      AD1 = 5'(i);
      #1;
      chk($sformatf("post_sweep_x%0d", i), RD1, 32'h0);
    end
    AD1 = 5'd3;
    #1;
    chk("busy1_x3_after_sweep", {31'b0, busy1}, 32'h0);
    idle_inputs();

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      AD1 = tbl[i].ad1; AD2 = tbl[i].ad2; AD3 = tbl[i].ad3; WE3 = tbl[i].we;
      WD3 = tbl[i].wd; pend_set = tbl[i].ps; pend_addr = tbl[i].pa;
      settle();
      chk($sformatf("tbl%0d_rd1", i), RD1, tbl[i].e_rd1);
      chk($sformatf("tbl%0d_rd2", i), RD2, tbl[i].e_rd2);
      chk($sformatf("tbl%0d_a0", i), a0, tbl[i].e_a0);
      chk($sformatf("tbl%0d_busy1", i), {31'b0, busy1}, {31'b0, tbl[i].e_b1});
      chk($sformatf("tbl%0d_busy2", i), {31'b0, busy2}, {31'b0, tbl[i].e_b2});
      advance();
    end

    // Same-cycle write/read of a pending register.
    idle_inputs();
    pend_set = 1'b1; pend_addr = 5'd12;
    advance();
    idle_inputs();
    AD1 = 5'd12; WE3 = 1'b1; AD3 = 5'd12; WD3 = 32'hABCD;
    settle();
    chk("byp_rd1", RD1, BYP ? 32'hABCD : 32'h0);
    chk("byp_busy1", {31'b0, busy1}, BYP ? 32'h0 : 32'h1);
    advance();
    idle_inputs();
    AD1 = 5'd12;
    settle();
    chk("after_wr_rd1", RD1, 32'hABCD);
    chk("after_wr_busy1", {31'b0, busy1}, 32'h0);
    advance();

    // Reset asserted at sweep cycle 17 restarts the sweep.
    idle_inputs();
    do_reset(1);
    repeat (17) advance();
    chk("mid_sweep_busy", {31'b0, init_busy}, 32'h1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    sweep_count(1'b0, n);
    chk("restart_sweep_len", n, 32);
    AD2 = 5'd12;
    #1;
    chk("restart_cleared_x12", RD2, 32'h0);

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      AD1       = 5'($urandom_range(0, 15));
      AD2       = 5'($urandom_range(0, 15));
      AD3       = 5'($urandom_range(0, 15));
      WE3       = ($urandom_range(0, 1) == 1);
      WD3       = $urandom;
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = 5'($urandom_range(0, 15));
      settle();
      chk("rnd_rd1", RD1, m_rd(AD1));
      chk("rnd_rd2", RD2, m_rd(AD2));
      chk("rnd_a0", a0, m_rd(5'd10));
      chk("rnd_busy1", {31'b0, busy1}, {31'b0, m_busy(AD1)});
      chk("rnd_busy2", {31'b0, busy2}, {31'b0, m_busy(AD2)});
      chk("rnd_init_busy", {31'b0, init_busy}, (m_clear_left > 0) ? 32'h1 : 32'h0);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
